cache_perf_monitor: RTL and testbench

//  Parametrised performance monitor for the cache test harness. It observes the CPU-side

---
 rtl/cache_perf_monitor.sv | 169 ++++++++++++++++
 tb/tb_cache_perf_monitor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_perf_monitor.sv
// cache_perf_monitor
//   Performance monitor for the CPU-to-cache access stream. It counts cycles,
//   accesses, writes, hits, misses and stall cycles, and it records the last
//   and the maximum miss latency. A snapshot bank freezes the live counters.
//   A registered read mux exports either the live set or the snapshot set.
//
// Parameters
//   CNT_W     width of every counter and of rd_data (4..32)
//   SATURATE  1: counters stick at all-ones, 0: counters wrap to zero
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   en         counting enable (FSM and lat_cnt run regardless)
//   clear      zero the live counters and ovf
//   snap       copy the live counters (pre-update values) into the snapshot bank
//   acc_valid  CPU presents an access
//   acc_write  presented access is a write
//   stall      cache stall; access accepted when acc_valid && !stall
//   rd_sel     0 cyc, 1 acc, 2 wr, 3 hit, 4 miss, 5 stall_cyc, 6 last_lat, 7 max_lat
//   rd_snap    1: read snapshot bank, 0: read live counters
//   rd_data    selected counter, one cycle of latency
//   ovf        sticky: some counter was incremented from all-ones
//   in_miss    FSM is in MISS
//
// FSM states
//   state | meaning
//   IDLE  | no outstanding miss; an unstalled access is a hit
//   MISS  | an access is stalled; lat_cnt counts its stalled cycles

module cache_perf_monitor #(
  parameter int CNT_W    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             snap,
  input  logic             acc_valid,
  input  logic             acc_write,
  input  logic             stall,
  input  logic [2:0]       rd_sel,
  input  logic             rd_snap,
  output logic [CNT_W-1:0] rd_data,
  output logic             ovf,
  output logic             in_miss
);

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam int               N_INC    = 6;
  localparam int               LAST_LAT = 6;
  localparam int               MAX_LAT  = 7;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;

  logic [CNT_W-1:0] live_q [8];
  logic [CNT_W-1:0] snap_q [8];
  logic [CNT_W-1:0] inc_val [N_INC];
  logic [N_INC-1:0] inc;
  logic [CNT_W-1:0] max_nxt;
  logic             ovf_set;

  logic accept, hit_ev, miss_ev, done_ev, stall_ev;

  assign accept   = acc_valid && !stall;
  assign stall_ev = acc_valid && stall;
  assign hit_ev   = (state_q == IDLE) && accept;
  assign miss_ev  = (state_q == IDLE) && stall_ev;
  assign done_ev  = (state_q == MISS) && accept;

  assign in_miss  = (state_q == MISS);

  // Next state and miss-latency counter.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    case (state_q)
      IDLE: begin
        if (miss_ev) begin
          lat_cnt_d = ONE;
          state_d   = MISS;
        end
      end
      MISS: begin
        if (done_ev) begin
          state_d = IDLE;
        end else if (lat_cnt_q != ALL_ONES) begin
          // Latency always saturates; a wrapped latency would be meaningless.
          lat_cnt_d = lat_cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Increment requests, indexed like rd_sel.
  assign inc = {stall_ev, miss_ev, hit_ev, accept && acc_write, accept, 1'b1};

  always_comb begin
    ovf_set = 1'b0;
    for (int i = 0; i < N_INC; i++) begin
      inc_val[i] = live_q[i];
      if (en && inc[i]) begin
        if (live_q[i] == ALL_ONES) begin
          ovf_set    = 1'b1;
          inc_val[i] = SATURATE ? ALL_ONES : '0;
        end else begin
          inc_val[i] = live_q[i] + ONE;
        end
      end
    end
  end

  assign max_nxt = (lat_cnt_q > live_q[MAX_LAT]) ? lat_cnt_q : live_q[MAX_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      rd_data   <= '0;
      ovf       <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        live_q[i] <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;

      // Both the snapshot and the read mux see the values from before this
      // edge, which makes snap+clear an atomic read-and-reset.
      if (snap) begin
        for (int i = 0; i < 8; i++) begin
          snap_q[i] <= live_q[i];
        end
      end
      rd_data <= rd_snap ? snap_q[rd_sel] : live_q[rd_sel];

      if (clear) begin
        ovf <= 1'b0;
        for (int i = 0; i < 8; i++) begin
          live_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < N_INC; i++) begin
          live_q[i] <= inc_val[i];
        end
        if (en && done_ev) begin
          live_q[LAST_LAT] <= lat_cnt_q;
          live_q[MAX_LAT]  <= max_nxt;
        end
        if (ovf_set) begin
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_perf_monitor.sv
module tb_cache_perf_monitor;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clear;
  logic        snap;
  logic        acc_valid;
  logic        acc_write;
  logic        stall;
  logic [2:0]  rd_sel;
  logic        rd_snap;

  logic [15:0] rd_data;
  logic        ovf;
  logic        in_miss;
  logic [3:0]  rd_data_s4;
  logic        ovf_s4;
  logic        in_miss_s4;
  logic [3:0]  rd_data_w4;
  logic        ovf_w4;
  logic        in_miss_w4;

  int n_tests = 0;
  int n_fail  = 0;

  cache_perf_monitor #(.CNT_W(16), .SATURATE(1'b1)) u_dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .snap(snap),
    .acc_valid(acc_valid), .acc_write(acc_write), .stall(stall),
    .rd_sel(rd_sel), .rd_snap(rd_snap),
    .rd_data(rd_data), .ovf(ovf), .in_miss(in_miss)
  );

  cache_perf_monitor #(.CNT_W(4), .SATURATE(1'b1)) u_dut_s4 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .snap(snap),
    .acc_valid(acc_valid), .acc_write(acc_write), .stall(stall),
    .rd_sel(rd_sel), .rd_snap(rd_snap),
    .rd_data(rd_data_s4), .ovf(ovf_s4), .in_miss(in_miss_s4)
  );

  cache_perf_monitor #(.CNT_W(4), .SATURATE(1'b0)) u_dut_w4 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .snap(snap),
    .acc_valid(acc_valid), .acc_write(acc_write), .stall(stall),
    .rd_sel(rd_sel), .rd_snap(rd_snap),
    .rd_data(rd_data_w4), .ovf(ovf_w4), .in_miss(in_miss_w4)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] sel, input logic from_snap);
    rd_sel  = sel;
    rd_snap = from_snap;
    tick(1);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] sel, input logic from_snap,
                        input logic [31:0] exp);
    rd(sel, from_snap);
    check(tag, 32'(rd_data), exp);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    en        = 1'b0;
    clear     = 1'b0;
    snap      = 1'b0;
    acc_valid = 1'b0;
    acc_write = 1'b0;
    stall     = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    en        = 1'b1;
    clear     = 1'b0;
    snap      = 1'b0;
    acc_valid = 1'b0;
    acc_write = 1'b0;
    stall     = 1'b0;
    rd_sel    = 3'd0;
    rd_snap   = 1'b0;

    // T1: reset state, then 10 idle cycles
    tick(2);
    check("t1_rst_rd_data", 32'(rd_data), 0);
    check("t1_rst_in_miss", 32'(in_miss), 0);
    rst = 1'b0;
    tick(10);
    en = 1'b0;
    rd_chk("t1_cyc", 3'd0, 1'b0, 10);
    rd_chk("t1_cyc_hold", 3'd0, 1'b0, 10);
    for (int i = 1; i < 8; i++) begin
      rd_chk($sformatf("t1_cnt%0d", i), 3'(i), 1'b0, 0);
    end
    rd_chk("t1_snap_cyc", 3'd0, 1'b1, 0);
    check("t1_ovf", 32'(ovf), 0);

    // T2: four back-to-back hits, one write
    do_reset();
    en        = 1'b1;
    acc_valid = 1'b1;
    acc_write = 1'b1;
    tick(1);
    acc_write = 1'b0;
    tick(3);
    acc_valid = 1'b0;
    en        = 1'b0;
    rd_chk("t2_acc", 3'd1, 1'b0, 4);
    rd_chk("t2_wr", 3'd2, 1'b0, 1);
    rd_chk("t2_hit", 3'd3, 1'b0, 4);
    rd_chk("t2_miss", 3'd4, 1'b0, 0);
    rd_chk("t2_stall", 3'd5, 1'b0, 0);
    check("t2_in_miss", 32'(in_miss), 0);

    // T3: misses of latency 3 then 5
    do_reset();
    en        = 1'b1;
    acc_valid = 1'b1;
    stall     = 1'b1;
    tick(3);
    check("t3_in_miss_stalled", 32'(in_miss), 1);
    stall = 1'b0;
    tick(1);
    check("t3_in_miss_done", 32'(in_miss), 0);
    stall = 1'b1;
    tick(5);
    stall = 1'b0;
    tick(1);
    acc_valid = 1'b0;
    en        = 1'b0;
    rd_chk("t3_miss", 3'd4, 1'b0, 2);
    rd_chk("t3_stall", 3'd5, 1'b0, 8);
    rd_chk("t3_last_lat", 3'd6, 1'b0, 5);
    rd_chk("t3_max_lat", 3'd7, 1'b0, 5);
    rd_chk("t3_hit", 3'd3, 1'b0, 0);
    rd_chk("t3_acc", 3'd1, 1'b0, 2);
    rd_chk("t3_cyc", 3'd0, 1'b0, 10);

    // T5: atomic snap + clear after T3
    snap  = 1'b1;
    clear = 1'b1;
    tick(1);
    snap  = 1'b0;
    clear = 1'b0;
    rd_chk("t5_snap_miss", 3'd4, 1'b1, 2);
    rd_chk("t5_snap_stall", 3'd5, 1'b1, 8);
    rd_chk("t5_snap_max", 3'd7, 1'b1, 5);
    rd_chk("t5_snap_cyc", 3'd0, 1'b1, 10);
    rd_chk("t5_live_miss", 3'd4, 1'b0, 0);
    rd_chk("t5_live_max", 3'd7, 1'b0, 0);
    check("t5_ovf", 32'(ovf), 0);

    // T4: overflow, saturate vs wrap at CNT_W=4
    do_reset();
    en = 1'b1;
    tick(20);
    en = 1'b0;
    rd(3'd0, 1'b0);
    check("t4_cyc16", 32'(rd_data), 20);
    check("t4_cyc_sat", 32'(rd_data_s4), 15);
    check("t4_cyc_wrap", 32'(rd_data_w4), 4);
    check("t4_ovf16", 32'(ovf), 0);
    check("t4_ovf_sat", 32'(ovf_s4), 1);
    check("t4_ovf_wrap", 32'(ovf_w4), 1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("t4_ovf_sat_clr", 32'(ovf_s4), 0);
    check("t4_ovf_wrap_clr", 32'(ovf_w4), 0);

    // T6: reset during the second stall cycle of a miss
    do_reset();
    en        = 1'b1;
    acc_valid = 1'b1;
    stall     = 1'b1;
    tick(1);
    check("t6_in_miss", 32'(in_miss), 1);
    rst = 1'b1;
    tick(1);
    check("t6_in_miss_rst", 32'(in_miss), 0);
    rst       = 1'b0;
    acc_valid = 1'b0;
    stall     = 1'b0;
    en        = 1'b0;
    rd_chk("t6_miss_rst", 3'd4, 1'b0, 0);
    rd_chk("t6_stall_rst", 3'd5, 1'b0, 0);
    rd_chk("t6_cyc_rst", 3'd0, 1'b0, 0);
    en        = 1'b1;
    acc_valid = 1'b1;
    tick(1);
    acc_valid = 1'b0;
    en        = 1'b0;
    check("t6_in_miss_after", 32'(in_miss), 0);
    rd_chk("t6_hit", 3'd3, 1'b0, 1);
    rd_chk("t6_acc", 3'd1, 1'b0, 1);
    rd_chk("t6_miss", 3'd4, 1'b0, 0);
    rd_chk("t6_last_lat", 3'd6, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
